// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV64 func_3
// encodings, the alignment check and the byte-strobe pattern per access size.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } t_lsu_state;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size lives in func_3[1:0] for both loads and stores.
    function automatic logic f_misaligned(input logic [2:0] func_3, input logic [2:0] offset);
        logic ma;
        case (func_3[1:0])
            2'b00:   ma = 1'b0;
            2'b01:   ma = (offset[0] != 1'b0);
            2'b10:   ma = (offset[1:0] != 2'b00);
            default: ma = (offset != 3'b000);
        endcase
        return ma;
    endfunction

    function automatic logic [7:0] f_size_strb(input logic [1:0] size);
        logic [7:0] strb;
        case (size)
            2'b00:   strb = 8'h01;
            2'b01:   strb = 8'h03;
            2'b10:   strb = 8'h0F;
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word out of the
// 64-bit memory word and sign- or zero-extends it according to func_3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func_3_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] data_o
);

    logic [2:0]  lane_s;
    logic [63:0] shifted_s;

    // Select the naturally aligned lane for the access size, then extend it.
    always_comb begin
        lane_s    = 3'b000;
        shifted_s = 64'd0;
        data_o    = 64'd0;
        case (func_3_i[1:0])
            2'b00:   lane_s = offset_i;
            2'b01:   lane_s = {offset_i[2:1], 1'b0};
            2'b10:   lane_s = {offset_i[2], 2'b00};
            default: lane_s = 3'b000;
        endcase
        shifted_s = rdata_i >> {lane_s, 3'b000};
        case (func_3_i)
            F3_B:    data_o = {{56{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    data_o = {{48{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    data_o = {{32{shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    data_o = shifted_s;
            F3_BU:   data_o = {56'd0, shifted_s[7:0]};
            F3_HU:   data_o = {48'd0, shifted_s[15:0]};
            F3_WU:   data_o = {32'd0, shifted_s[31:0]};
            default: data_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the execute stage and the 64-bit data port.
// Optional response timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_start,
    input  logic                  i_we,
    input  logic [2:0]            i_func_3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_load_addr_ma,
    output logic                  o_store_addr_ma,
    output logic                  o_illegal,
    output logic                  o_access_fault,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]            o_mem_wstrb,
    input  logic                  i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    t_lsu_state            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            func3_q, func3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ld_ma_q, ld_ma_d;
    logic                  st_ma_q, st_ma_d;
    logic                  ill_q, ill_d;
    logic                  af_q, af_d;
    logic                  illegal_s;
    logic                  misaligned_s;
    logic                  timeout_s;
    logic [DATA_WIDTH-1:0] load_data_s;

    lsu_load_align u_load_align (
        .func_3_i (func3_q),
        .offset_i (addr_q[2:0]),
        .rdata_i  (i_mem_rdata),
        .data_o   (load_data_s)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait-cycle counter; any state other than WAIT leaves it at zero for the next entry.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (state_q == WAIT && !i_mem_rsp_valid) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Wait-cycle counter register.
    always_ff @(posedge clk) begin
        if (arst) cnt_q <= {CNT_W{1'b0}};
        else      cnt_q <= cnt_d;
    end

    assign timeout_s = (state_q == WAIT) && !i_mem_rsp_valid
                       && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the counter WAIT never expires.
    assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

    assign illegal_s    = i_we ? i_func_3[2] : (i_func_3 == 3'b111);
    assign misaligned_s = !illegal_s && f_misaligned(i_func_3, i_addr[2:0]);

    // Next-state and datapath latch logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        ld_ma_d = ld_ma_q;
        st_ma_d = st_ma_q;
        ill_d   = ill_q;
        af_d    = af_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    we_d    = i_we;
                    func3_d = i_func_3;
                    addr_d  = i_addr;
                    wdata_d = i_we ? (i_wdata << {i_addr[2:0], 3'b000}) : {DATA_WIDTH{1'b0}};
                    wstrb_d = i_we ? (f_size_strb(i_func_3[1:0]) << i_addr[2:0]) : 8'h00;
                    ill_d   = illegal_s;
                    ld_ma_d = misaligned_s && !i_we;
                    st_ma_d = misaligned_s && i_we;
                    af_d    = 1'b0;
                    state_d = (illegal_s || misaligned_s) ? DONE : REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (i_mem_req_ready) state_d = WAIT;
                else                 state_d = REQ;
            end
            WAIT: begin
                if (i_mem_rsp_valid) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = load_data_s;
                    else       rdata_d = rdata_q;
                end else if (timeout_s) begin
                    state_d = DONE;
                    af_d    = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
                ld_ma_d = 1'b0;
                st_ma_d = 1'b0;
                ill_d   = 1'b0;
                af_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            wstrb_q <= 8'h00;
            rdata_q <= {DATA_WIDTH{1'b0}};
            ld_ma_q <= 1'b0;
            st_ma_q <= 1'b0;
            ill_q   <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            ld_ma_q <= ld_ma_d;
            st_ma_q <= st_ma_d;
            ill_q   <= ill_d;
            af_q    <= af_d;
        end
    end

    assign o_busy          = (state_q != IDLE);
    assign o_done          = (state_q == DONE);
    assign o_rdata         = rdata_q;
    assign o_load_addr_ma  = ld_ma_q;
    assign o_store_addr_ma = st_ma_q;
    assign o_illegal       = ill_q;
    assign o_access_fault  = af_q;
    assign o_mem_req_valid = (state_q == REQ);
    assign o_mem_addr      = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign o_mem_we        = we_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_wstrb     = wstrb_q;

endmodule
